// File: rtl/divider_pkg.sv
// ==========================================================================
// divider_pkg - FSM encodings and counter sizing for seq_restoring_divider
// Rev 1.0
// ==========================================================================
`default_nettype none

package divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage : divider_pkg

`default_nettype wire

// File: rtl/div_sub_step.sv
// ==========================================================================
// div_sub_step - WIDTH+1-bit trial subtract returning difference and borrow
// Rev 1.0
// ==========================================================================
`default_nettype none

module div_sub_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   p_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   diff_o,
  output logic             borrow_o
);

  // One extra bit above the partial remainder catches the borrow.
  logic [WIDTH+1:0] w_full;

  assign w_full   = {1'b0, p_i} - {2'b00, d_i};
  assign diff_o   = w_full[WIDTH:0];
  assign borrow_o = w_full[WIDTH+1];

endmodule : div_sub_step

`default_nettype wire

// File: rtl/seq_restoring_divider.sv
// ==========================================================================
// seq_restoring_divider - one quotient bit per clock; DIV_SIGNED_EN selects
// two's-complement operands (truncate toward zero). Rev 1.0
// ==========================================================================
`default_nettype none

module seq_restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] shq_q, shq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   w_p;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic             w_unused_diff_msb;
  logic [WIDTH-1:0] w_acc_nx;
  logic [WIDTH-1:0] w_shq_nx;
  logic [WIDTH-1:0] w_dnd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_quo_fin;
  logic [WIDTH-1:0] w_rem_fin;

  assign w_p = {acc_q, shq_q[WIDTH-1]};

  div_sub_step #(
    .WIDTH (WIDTH)
  ) u_sub_step (
    .p_i      (w_p),
    .d_i      (dvs_q),
    .diff_o   (w_diff),
    .borrow_o (w_borrow)
  );

  // The remainder stays below the divisor, so the top difference bit is 0 whenever it is kept.
  assign w_unused_diff_msb = w_diff[WIDTH];
  assign w_acc_nx          = w_borrow ? w_p[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_shq_nx          = {shq_q[WIDTH-2:0], ~w_borrow};

`ifdef DIV_SIGNED_EN
  logic negq_q, negq_d;
  logic negr_q, negr_d;

  assign w_dnd_mag = dividend[WIDTH-1] ? (-dividend) : dividend;
  assign w_dvs_mag = divisor[WIDTH-1]  ? (-divisor)  : divisor;
  assign w_quo_fin = negq_q ? (-w_shq_nx) : w_shq_nx;
  assign w_rem_fin = negr_q ? (-w_acc_nx) : w_acc_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end

  always_comb begin
    negq_d = negq_q;
    negr_d = negr_q;
    if (state_q == ST_IDLE && in_valid) begin
      negq_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      negr_d = dividend[WIDTH-1];
    end
  end
`else
  assign w_dnd_mag = dividend;
  assign w_dvs_mag = divisor;
  assign w_quo_fin = w_shq_nx;
  assign w_rem_fin = w_acc_nx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      shq_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      shq_q   <= shq_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    shq_d     = shq_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    dbz_d     = dbz_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            acc_d   = '0;
            shq_d   = w_dnd_mag;
            dvs_d   = w_dvs_mag;
            cnt_d   = CW'(WIDTH - 1);
            dbz_d   = 1'b0;
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        acc_d = w_acc_nx;
        shq_d = w_shq_nx;
        cnt_d = cnt_q - CW'(1);
        // Sign fix-up rides on the final iteration so it costs no extra cycle.
        if (cnt_q == '0) begin
          quo_d   = w_quo_fin;
          rem_d   = w_rem_fin;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule : seq_restoring_divider

`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
// ==========================================================================
// tb_seq_restoring_divider - directed scoreboard bench for the divider
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_seq_restoring_divider;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int   tests;
  int   failures;
  exp_t sb[$];

  seq_restoring_divider #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      int sa;
      int sb_v;
      int qq;
      int rr;
      sa   = int'($signed(a));
      sb_v = int'($signed(b));
      qq   = sa / sb_v;
      rr   = sa % sb_v;
      e.q  = qq[W-1:0];
      e.r  = rr[W-1:0];
`else
      e.q  = a / b;
      e.r  = a % b;
`endif
      e.z  = 1'b0;
    end
    return e;
  endfunction

  // Accept one operand pair, measure latency, back-pressure for hold cycles, then consume.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    int   lat;
    exp_t e;
    check("in_ready_before", 32'(in_ready), 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = ~a;
    divisor  = 8'h5A;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), (b == '0) ? 32'd1 : 32'(W + 1));
    e = sb.pop_front();
    check("quotient", 32'(quotient), 32'(e.q));
    check("remainder", 32'(remainder), 32'(e.r));
    check("div_by_zero", 32'(div_by_zero), 32'(e.z));
    check("in_ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_quotient", 32'(quotient), 32'(e.q));
      check("hold_remainder", 32'(remainder), 32'(e.r));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("valid_after_hs", 32'(out_valid), 32'd0);
    check("in_ready_after_hs", 32'(in_ready), 32'd1);
    check("idle_quotient", 32'(quotient), 32'(e.q));
    check("idle_remainder", 32'(remainder), 32'(e.r));
  endtask

  initial begin
    tests     = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_div(8'd100, 8'd7, 0);
    run_div(8'd255, 8'd1, 0);
    run_div(8'd3, 8'd10, 0);
    run_div(8'd5, 8'd0, 0);
    run_div(8'd3, 8'd10, 0);
    run_div(8'd200, 8'd9, 5);
    run_div(8'd0, 8'd13, 0);
    run_div(8'd254, 8'd255, 2);

    // Abort four clocks into RUN; the aborted result must never appear.
    dividend = 8'd100;
    divisor  = 8'd7;
    in_valid = 1'b1;
    sb.push_back(model(8'd100, 8'd7));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_abort_valid", 32'(out_valid), 32'd0);
    run_div(8'd50, 8'd5, 0);

`ifdef DIV_SIGNED_EN
    run_div(8'h9C, 8'd7, 0);
    run_div(8'h80, 8'hFF, 0);
    run_div(8'd100, 8'hF9, 0);
    run_div(8'h9C, 8'hF9, 1);
    run_div(8'h9C, 8'd0, 0);
`else
    run_div(8'h80, 8'hFF, 0);
    run_div(8'd255, 8'd16, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule : tb_seq_restoring_divider

`default_nettype wire
